// File: rtl/hazard_ctrl_if.sv
// Decode/memory-side request signals and pipeline control outputs of the hazard controller.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_WIDTH = 16
);
  logic                 id_valid;
  logic                 rs1_re;
  logic [4:0]           rs1_addr;
  logic                 rs2_re;
  logic [4:0]           rs2_addr;
  logic                 rd_we;
  logic [4:0]           rd_addr;
  logic                 id_is_load;
  logic                 ex_branch_taken;
  logic                 mem_req;
  logic                 mem_ack;
  logic                 stall_pc;
  logic                 stall_ifid;
  logic                 bubble_idex;
  logic                 flush_ifid;
  logic                 freeze;
  logic [CNT_WIDTH-1:0] stall_cnt;

  modport master (
    output id_valid, rs1_re, rs1_addr, rs2_re, rs2_addr, rd_we, rd_addr,
           id_is_load, ex_branch_taken, mem_req, mem_ack,
    input  stall_pc, stall_ifid, bubble_idex, flush_ifid, freeze, stall_cnt
  );

  modport slave (
    input  id_valid, rs1_re, rs1_addr, rs2_re, rs2_addr, rd_we, rd_addr,
           id_is_load, ex_branch_taken, mem_req, mem_ack,
    output stall_pc, stall_ifid, bubble_idex, flush_ifid, freeze, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core: in-flight rd scoreboard,
// load-use / data hazard detection, branch flush and data-memory wait arbitration.
module hazard_ctrl #(
  parameter bit          FORWARDING   = 1'b1,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  localparam int unsigned FCW = 3;

  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_e;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
  } tag_t;

  typedef struct packed {
    tag_t tag;
    logic ld;
  } slot_t;

  state_e               state_q, state_d;
  logic [FCW-1:0]       fcnt_q, fcnt_d;
  slot_t                ex_q;
  tag_t                 mem_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic stall_pc_c, stall_ifid_c, bubble_c, flush_c, freeze_c;
  logic mem_wait_c, ex_hit_c, mem_hit_c, hazard_c, issue_c;

  function automatic logic match(input tag_t s, input logic r1e, input logic [4:0] r1,
                                 input logic r2e, input logic [4:0] r2);
    return s.v & ((r1e & (r1 == s.rd)) | (r2e & (r2 == s.rd)));
  endfunction

  // Only ex needs the load flag; a retiring wb write never blocks decode (write-through),
  // so the wb slot carries no state that could influence any output.
  assign ex_hit_c  = match(ex_q.tag, bus.rs1_re, bus.rs1_addr, bus.rs2_re, bus.rs2_addr);
  assign mem_hit_c = match(mem_q, bus.rs1_re, bus.rs1_addr, bus.rs2_re, bus.rs2_addr);
  assign hazard_c  = bus.id_valid & ((ex_hit_c & (ex_q.ld | ~FORWARDING)) |
                                     (mem_hit_c & ~FORWARDING));
  assign mem_wait_c = bus.mem_req & ~bus.mem_ack;
  assign issue_c    = bus.id_valid & ~stall_ifid_c & ~flush_c;

  // Next-state and control decode; priority is mem wait > branch > hazard.
  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    stall_pc_c   = 1'b0;
    stall_ifid_c = 1'b0;
    bubble_c     = 1'b0;
    flush_c      = 1'b0;
    freeze_c     = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_wait_c) begin
          freeze_c     = 1'b1;
          stall_pc_c   = 1'b1;
          stall_ifid_c = 1'b1;
          state_d      = MEM_WAIT;
        end else if (bus.ex_branch_taken) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            fcnt_d  = FCW'(FLUSH_CYCLES - 1);
          end
        end else if (hazard_c) begin
          stall_pc_c   = 1'b1;
          stall_ifid_c = 1'b1;
          bubble_c     = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!bus.mem_ack) begin
          freeze_c     = 1'b1;
          stall_pc_c   = 1'b1;
          stall_ifid_c = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        if (mem_wait_c) begin
          freeze_c     = 1'b1;
          stall_pc_c   = 1'b1;
          stall_ifid_c = 1'b1;
        end else begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
          if (fcnt_q == FCW'(1)) state_d = RUN;
          else                   fcnt_d  = fcnt_q - FCW'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      ex_q    <= '0;
      mem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      if (!freeze_c) begin
        mem_q <= ex_q.tag;
        if (issue_c) begin
          ex_q.tag.v  <= bus.rd_we & (bus.rd_addr != 5'd0);
          ex_q.tag.rd <= bus.rd_addr;
          ex_q.ld     <= bus.id_is_load;
        end else begin
          ex_q <= '0;
        end
      end
      if (stall_pc_c && (cnt_q != {CNT_WIDTH{1'b1}})) cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  // Controls are forced low while reset is held, whatever the inputs are doing.
  assign bus.stall_pc    = rst & stall_pc_c;
  assign bus.stall_ifid  = rst & stall_ifid_c;
  assign bus.bubble_idex = rst & bubble_c;
  assign bus.flush_ifid  = rst & flush_c;
  assign bus.freeze      = rst & freeze_c;
  assign bus.stall_cnt   = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a forwarding and a non-forwarding instance share one stimulus
// stream and are checked every cycle against a per-configuration reference model.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_WIDTH(16)) bf ();
  hazard_ctrl_if #(.CNT_WIDTH(4))  bn ();

  hazard_ctrl #(.FORWARDING(1'b1), .FLUSH_CYCLES(2), .CNT_WIDTH(16)) u_fwd (
    .clk(clk), .rst(rst), .bus(bf.slave));
  hazard_ctrl #(.FORWARDING(1'b0), .FLUSH_CYCLES(3), .CNT_WIDTH(4)) u_nof (
    .clk(clk), .rst(rst), .bus(bn.slave));

  int ncmp = 0;
  int nerr = 0;

  // Shared stimulus values
  logic       i_idv, i_r1e, i_r2e, i_we, i_ld, i_br, i_mreq, i_mack;
  logic [4:0] i_r1, i_r2, i_rd;

  // Reference model state; index 0 = forwarding/2-flush/16-bit, 1 = no-forward/3-flush/4-bit
  bit         m_wait [2];
  int         m_fl   [2];
  int         m_cnt  [2];
  bit         sv     [2][2];
  logic [4:0] srd    [2][2];
  bit         sld    [2][2];

  function automatic int flush_len(input int c);
    return (c == 0) ? 2 : 3;
  endfunction

  function automatic int cnt_max(input int c);
    return (c == 0) ? 65535 : 15;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      m_wait[c] = 1'b0;
      m_fl[c]   = 0;
      m_cnt[c]  = 0;
      for (int k = 0; k < 2; k++) begin
        sv[c][k]  = 1'b0;
        srd[c][k] = 5'd0;
        sld[c][k] = 1'b0;
      end
    end
  endfunction

  function automatic bit hits(input int c, input int k);
    return sv[c][k] && ((i_r1e && i_r1 == srd[c][k]) || (i_r2e && i_r2 == srd[c][k]));
  endfunction

  // Expected {stall_pc, stall_ifid, bubble_idex, flush_ifid, freeze}
  function automatic int model_out(input int c);
    bit hz, mw;
    hz = (c == 0) ? (i_idv && hits(c, 0) && sld[c][0]) : (i_idv && (hits(c, 0) || hits(c, 1)));
    mw = i_mreq && !i_mack;
    if (m_wait[c])   return i_mack ? 0 : 'b11001;
    if (m_fl[c] > 0) return mw ? 'b11001 : 'b00110;
    if (mw)          return 'b11001;
    if (i_br)        return 'b00110;
    if (hz)          return 'b11100;
    return 0;
  endfunction

  function automatic void model_commit(input int c, input int e);
    bit mw, issue;
    mw = i_mreq && !i_mack;
    if (m_wait[c]) begin
      if (i_mack) m_wait[c] = 1'b0;
    end else if (m_fl[c] > 0) begin
      if (!mw) m_fl[c]--;
    end else if (mw) begin
      m_wait[c] = 1'b1;
    end else if (i_br) begin
      m_fl[c] = flush_len(c) - 1;
    end
    if (e[0] == 1'b0) begin
      issue     = i_idv && !e[3] && !e[1];
      sv[c][1]  = sv[c][0];
      srd[c][1] = srd[c][0];
      sld[c][1] = sld[c][0];
      sv[c][0]  = issue && i_we && (i_rd != 5'd0);
      srd[c][0] = issue ? i_rd : 5'd0;
      sld[c][0] = issue && i_ld;
    end
    if (e[4] && m_cnt[c] < cnt_max(c)) m_cnt[c]++;
  endfunction

  function automatic int obs_vec(input int c);
    if (c == 0) return int'({bf.stall_pc, bf.stall_ifid, bf.bubble_idex, bf.flush_ifid, bf.freeze});
    return int'({bn.stall_pc, bn.stall_ifid, bn.bubble_idex, bn.flush_ifid, bn.freeze});
  endfunction

  function automatic int obs_cnt(input int c);
    return (c == 0) ? int'(bf.stall_cnt) : int'(bn.stall_cnt);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_in(input logic idv, input logic r1e, input logic [4:0] r1,
                        input logic r2e, input logic [4:0] r2, input logic we,
                        input logic [4:0] rd, input logic ld, input logic br,
                        input logic mreq, input logic mack);
    i_idv = idv; i_r1e = r1e; i_r1 = r1; i_r2e = r2e; i_r2 = r2;
    i_we = we; i_rd = rd; i_ld = ld; i_br = br; i_mreq = mreq; i_mack = mack;
  endtask

  task automatic drive();
    bf.id_valid = i_idv; bf.rs1_re = i_r1e; bf.rs1_addr = i_r1; bf.rs2_re = i_r2e;
    bf.rs2_addr = i_r2; bf.rd_we = i_we; bf.rd_addr = i_rd; bf.id_is_load = i_ld;
    bf.ex_branch_taken = i_br; bf.mem_req = i_mreq; bf.mem_ack = i_mack;
    bn.id_valid = i_idv; bn.rs1_re = i_r1e; bn.rs1_addr = i_r1; bn.rs2_re = i_r2e;
    bn.rs2_addr = i_r2; bn.rd_we = i_we; bn.rd_addr = i_rd; bn.id_is_load = i_ld;
    bn.ex_branch_taken = i_br; bn.mem_req = i_mreq; bn.mem_ack = i_mack;
  endtask

  // One clock cycle: drive at negedge, check combinational response, advance the model.
  task automatic tick();
    int e;
    @(negedge clk);
    drive();
    #1;
    for (int c = 0; c < 2; c++) begin
      e = model_out(c);
      chk((c == 0) ? "ctrl_fwd" : "ctrl_nof", obs_vec(c), e);
      chk((c == 0) ? "cnt_fwd" : "cnt_nof", obs_cnt(c), m_cnt[c]);
      model_commit(c, e);
    end
  endtask

  task automatic nop(input int n);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asynchronous reset asserted mid-cycle with a memory wait pending on the inputs.
  task automatic do_reset();
    set_in(1, 1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 1, 1, 0);
    drive();
    rst = 1'b0;
    #1;
    chk("rst_ctrl_fwd", obs_vec(0), 0);
    chk("rst_ctrl_nof", obs_vec(1), 0);
    chk("rst_cnt_fwd", obs_cnt(0), 0);
    chk("rst_cnt_nof", obs_cnt(1), 0);
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive();
    #2;
    do_reset();

    // lw x5 then add x6,x5,x1
    set_in(1, 1, 5'd1, 0, 5'd0, 1, 5'd5, 1, 0, 0, 0); tick();
    set_in(1, 1, 5'd5, 1, 5'd1, 1, 5'd6, 0, 0, 0, 0); tick(); tick(); tick();
    nop(1);
    chk("loaduse_cnt_fwd", obs_cnt(0), 1);
    chk("loaduse_cnt_nof", obs_cnt(1), 2);

    // lw x0 then reader of x0; addi x3 then reader of x3
    set_in(1, 1, 5'd2, 0, 5'd0, 1, 5'd0, 1, 0, 0, 0); tick();
    set_in(1, 1, 5'd0, 1, 5'd0, 1, 5'd4, 0, 0, 0, 0); tick();
    nop(3);
    set_in(1, 1, 5'd1, 0, 5'd0, 1, 5'd3, 0, 0, 0, 0); tick();
    set_in(1, 0, 5'd0, 1, 5'd3, 1, 5'd7, 0, 0, 0, 0); tick(); tick(); tick();
    nop(3);

    // Taken branch pulse
    set_in(1, 1, 5'd1, 0, 5'd0, 1, 5'd8, 0, 1, 0, 0); tick();
    set_in(1, 1, 5'd1, 0, 5'd0, 1, 5'd8, 0, 0, 0, 0); tick(); tick(); tick(); tick();

    // Memory wait of three cycles then ack
    set_in(1, 1, 5'd8, 0, 5'd0, 1, 5'd9, 0, 0, 1, 0); tick(); tick(); tick();
    set_in(1, 1, 5'd8, 0, 5'd0, 1, 5'd9, 0, 0, 1, 1); tick();
    nop(3);

    // Branch and load-use hazard in the same cycle
    set_in(1, 1, 5'd1, 0, 5'd0, 1, 5'd7, 1, 0, 0, 0); tick();
    set_in(1, 1, 5'd7, 0, 5'd0, 1, 5'd2, 0, 1, 0, 0); tick();
    nop(4);

    // Memory wait while flushing
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick(); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1); tick();
    nop(4);

    // Long wait to saturate the narrow counter
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1); tick();
    nop(1);
    chk("sat_cnt_nof", obs_cnt(1), 15);

    // Reset during the second cycle of a memory wait
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick(); tick();
    do_reset();
    nop(2);

    // Randomised traffic with small register indices to provoke matches
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        set_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
               5'($urandom_range(0, 3)), 1'($urandom_range(0, 2) == 0),
               1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 4) == 0),
               1'($urandom_range(0, 1)));
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
